fifo3_packer: RTL and testbench

Write-side producer for the 3-way FIFO. It accepts a serial byte stream over a valid/ready handshake and stages the bytes in a small in-order buffer. It presents up to three oldest bytes per cycle as a contiguous lane group on the FIFO write lanes and retires exactly the prefix the FIFO reports as accepted. An optional coalescing timer holds partial groups so that writes use full 3-lane rows where possible.

---
 rtl/fifo3_packer.sv | 153 +++++++++++++++
 tb/tb_fifo3_packer.sv | 182 ++++++++++++++++++
 2 files changed

// File: rtl/fifo3_packer.sv
// Serial byte stager feeding the three write lanes of the 3-way FIFO.
// Define PACKER_TIMEOUT_EN to hold partial groups for up to TIMEOUT cycles (or until flush).
module fifo3_packer #(
   parameter int DEPTH   = 6,
   parameter int TIMEOUT = 4
) (
   input  logic       clk,
   input  logic       reset,
   input  logic [7:0] in_data,
   input  logic       in_valid,
   output logic       in_ready,
   input  logic       flush,
   output logic [7:0] wr_data_0,
   output logic [7:0] wr_data_1,
   output logic [7:0] wr_data_2,
   output logic [2:0] wr_valid,
   input  logic [2:0] wr_able,
   output logic [3:0] count
);

   localparam logic [3:0] DEPTH_L = 4'(DEPTH);

`ifdef PACKER_TIMEOUT_EN
   localparam logic [3:0] TMO_LAST = 4'(TIMEOUT - 1);
   typedef enum logic [1:0] {S_IDLE, S_HOLD, S_SEND} state_t;
`else
   typedef enum logic [0:0] {S_IDLE, S_SEND} state_t;
`endif

   logic [7:0] r_mem [DEPTH];
   logic [3:0] r_head;
   logic [3:0] r_tail;
   logic [3:0] r_count;
   state_t     r_state;
   state_t     w_state_next;
   logic [2:0] w_valid;
   logic [2:0] w_hit;
   logic [1:0] w_acc;
   logic       w_push;
   logic [3:0] w_count_next;
   logic [3:0] w_idx1;
   logic [3:0] w_idx2;

`ifdef PACKER_TIMEOUT_EN
   logic [3:0] r_timer;
   logic [3:0] w_timer_next;
`else
   logic       w_unused_cfg;
   assign w_unused_cfg = flush | (TIMEOUT > 0);
`endif

   // acc never exceeds DEPTH (>=3), so one conditional subtract implements mod DEPTH
   function automatic logic [3:0] f_wrap(input logic [3:0] base, input logic [1:0] inc);
      logic [4:0] s;
      s = {1'b0, base} + {3'b000, inc};
      if (s >= {1'b0, DEPTH_L}) s = s - {1'b0, DEPTH_L};
      return s[3:0];
   endfunction

   assign in_ready     = (r_count != DEPTH_L);
   assign w_push       = in_valid && in_ready;
   assign w_idx1       = f_wrap(r_head, 2'd1);
   assign w_idx2       = f_wrap(r_head, 2'd2);
   assign wr_data_0    = r_mem[r_head];
   assign wr_data_1    = r_mem[w_idx1];
   assign wr_data_2    = r_mem[w_idx2];
   assign wr_valid     = w_valid;
   assign count        = r_count;
   assign w_hit        = wr_able & w_valid;
   assign w_count_next = r_count - {2'b00, w_acc} + {3'b000, w_push};

   always_comb begin
      w_valid = '0;
      if (r_state == S_SEND) begin
         if (r_count >= 4'd3)      w_valid = 3'b111;
         else if (r_count == 4'd2) w_valid = 3'b011;
         else if (r_count == 4'd1) w_valid = 3'b001;
      end
   end

   always_comb begin
      w_acc = 2'd0;
      if (w_hit[0]) begin
         w_acc = 2'd1;
         if (w_hit[1]) begin
            w_acc = 2'd2;
            if (w_hit[2]) w_acc = 2'd3;
         end
      end
   end

   always_comb begin
      w_state_next = r_state;
`ifdef PACKER_TIMEOUT_EN
      w_timer_next = r_timer;
`endif
      case (r_state)
         S_IDLE: begin
            if (w_push) begin
`ifdef PACKER_TIMEOUT_EN
               w_state_next = S_HOLD;
               w_timer_next = '0;
`else
               w_state_next = S_SEND;
`endif
            end
         end
`ifdef PACKER_TIMEOUT_EN
         S_HOLD: begin
            w_timer_next = r_timer + 4'd1;
            if (w_count_next >= 4'd3 || r_timer == TMO_LAST || flush) w_state_next = S_SEND;
         end
`endif
         S_SEND: begin
            if (w_count_next == '0) begin
               w_state_next = S_IDLE;
            end
`ifdef PACKER_TIMEOUT_EN
            else if (w_count_next < 4'd3 && w_acc != 2'd0) begin
               w_state_next = S_HOLD;
               w_timer_next = '0;
            end
`endif
         end
         default: w_state_next = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_head  <= '0;
         r_tail  <= '0;
         r_count <= '0;
         r_state <= S_IDLE;
`ifdef PACKER_TIMEOUT_EN
         r_timer <= '0;
`endif
      end else begin
         r_head  <= f_wrap(r_head, w_acc);
         if (w_push) r_tail <= f_wrap(r_tail, 2'd1);
         r_count <= w_count_next;
         r_state <= w_state_next;
`ifdef PACKER_TIMEOUT_EN
         r_timer <= w_timer_next;
`endif
      end
   end

   always_ff @(posedge clk) begin
      if (w_push) r_mem[r_tail] <= in_data;
   end

endmodule

// File: tb/tb_fifo3_packer.sv
// Directed and random checks of fifo3_packer against a queue-based reference model.
module tb_fifo3_packer;

   localparam int DEPTH   = 6;
   localparam int TIMEOUT = 4;
`ifdef PACKER_TIMEOUT_EN
   localparam bit TMO_EN = 1'b1;
`else
   localparam bit TMO_EN = 1'b0;
`endif

   logic       clk = 1'b0;
   logic       reset = 1'b1;
   logic [7:0] in_data = '0;
   logic       in_valid = 1'b0;
   logic       flush = 1'b0;
   logic [2:0] wr_able = '0;
   logic       in_ready;
   logic [7:0] wr_data_0, wr_data_1, wr_data_2;
   logic [2:0] wr_valid;
   logic [3:0] count;

   int tests = 0;
   int fails = 0;

   // reference model: byte queue plus release mode (0 idle, 1 holding, 2 sending)
   logic [7:0] q[$];
   int mode = 0;
   int age = 0;

   fifo3_packer #(.DEPTH(DEPTH), .TIMEOUT(TIMEOUT)) dut (
      .clk(clk), .reset(reset), .in_data(in_data), .in_valid(in_valid),
      .in_ready(in_ready), .flush(flush), .wr_data_0(wr_data_0),
      .wr_data_1(wr_data_1), .wr_data_2(wr_data_2), .wr_valid(wr_valid),
      .wr_able(wr_able), .count(count)
   );

   always #5 clk = ~clk;

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   function automatic int exp_lanes();
      int s;
      s = q.size();
      if (TMO_EN && mode != 2) return 0;
      return (s > 3) ? 3 : s;
   endfunction

   // Called just after a negedge: checks outputs, drives inputs, advances the model one clock.
   task automatic cycle(input logic v, input logic [7:0] d, input logic [2:0] able, input logic fl);
      int n, acc, ns;
      logic push;
      logic [2:0] expv;
      n = exp_lanes();
      expv = (n == 3) ? 3'b111 : (n == 2) ? 3'b011 : (n == 1) ? 3'b001 : 3'b000;
      chk("in_ready", in_ready, q.size() != DEPTH);
      chk("count", count, q.size());
      chk("wr_valid", wr_valid, expv);
      if (n > 0) chk("lane0", wr_data_0, q[0]);
      if (n > 1) chk("lane1", wr_data_1, q[1]);
      if (n > 2) chk("lane2", wr_data_2, q[2]);
      in_valid = v;
      in_data  = d;
      wr_able  = able;
      flush    = fl;
      acc = 0;
      while (acc < n && able[acc]) acc++;
      push = v && (q.size() != DEPTH);
      repeat (acc) void'(q.pop_front());
      if (push) q.push_back(d);
      ns = q.size();
      if (TMO_EN) begin
         case (mode)
            0: if (push) begin mode = 1; age = 0; end
            1: begin
               if (ns >= 3 || age == TIMEOUT - 1 || fl) mode = 2;
               age++;
            end
            default: begin
               if (ns == 0) mode = 0;
               else if (ns < 3 && acc > 0) begin mode = 1; age = 0; end
            end
         endcase
      end
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic drain();
      for (int i = 0; i < 60 && (q.size() != 0 || mode != 0); i++) cycle(1'b0, 8'h00, 3'b111, 1'b0);
      chk("drain_count", count, 0);
      chk("drain_valid", wr_valid, 0);
   endtask

   task automatic latency(input logic fl_test, input int exp);
      int k;
      cycle(1'b1, 8'h55, 3'b000, 1'b0);
      for (k = 1; k <= 20; k++) begin
         if (wr_valid !== 3'b000) break;
         cycle(1'b0, 8'h00, 3'b000, fl_test && k == 2);
      end
      chk(fl_test ? "latency_flush" : "latency", k, exp);
      chk("latency_valid", wr_valid, 3'b001);
      chk("latency_lane0", wr_data_0, 8'h55);
      drain();
   endtask

   task automatic reset_mid();
      in_valid = 1'b0;
      wr_able  = '0;
      flush    = 1'b0;
      reset    = 1'b1;
      #2;
      chk("rst_async_count", count, 0);
      chk("rst_async_valid", wr_valid, 0);
      @(posedge clk);
      @(negedge clk);
      chk("rst_count", count, 0);
      chk("rst_valid", wr_valid, 0);
      chk("rst_ready", in_ready, 1);
      reset = 1'b0;
      q.delete();
      mode = 0;
      age  = 0;
   endtask

   initial begin
      logic [2:0] able;
      repeat (2) @(negedge clk);
      chk("por_ready", in_ready, 1);
      chk("por_valid", wr_valid, 0);
      chk("por_count", count, 0);
      reset = 1'b0;
      repeat (3) cycle(1'b0, 8'h00, 3'b000, 1'b0);

      for (int i = 0; i < 6; i++) cycle(1'b1, 8'(8'h10 + i), 3'b111, 1'b0);
      drain();

      for (int i = 0; i < 5; i++) cycle(1'b1, 8'(8'hA0 + i), 3'b000, 1'b0);
      cycle(1'b0, 8'h00, 3'b011, 1'b0);
      cycle(1'b0, 8'h00, 3'b101, 1'b0);
      cycle(1'b0, 8'h00, 3'b010, 1'b0);
      cycle(1'b0, 8'h00, 3'b000, 1'b0);
      drain();

      for (int i = 0; i < 7; i++) cycle(1'b1, 8'(8'hC0 + i), 3'b000, 1'b0);
      cycle(1'b1, 8'hC6, 3'b111, 1'b0);
      cycle(1'b1, 8'hC6, 3'b000, 1'b0);
      cycle(1'b0, 8'h00, 3'b000, 1'b0);
      drain();

      latency(1'b0, TMO_EN ? TIMEOUT + 1 : 1);
      latency(1'b1, TMO_EN ? 3 : 1);

      for (int i = 0; i < 4; i++) cycle(1'b1, 8'(8'hE0 + i), 3'b000, 1'b0);
      reset_mid();
      repeat (2) cycle(1'b0, 8'h00, 3'b111, 1'b0);

      for (int i = 0; i < 400; i++) begin
         able = 3'($urandom);
         if (i >= 200 && $urandom_range(0, 2) != 0) able = 3'b000;
         cycle($urandom_range(0, 3) != 0, 8'($urandom), able, $urandom_range(0, 9) == 0);
      end
      drain();

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
